// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and the default operand width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add on {acc,low} for multiply, restoring
// shift-subtract on {rem,quot} for divide. Purely combinational.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] low_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;

  always_comb begin
    sum     = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc, low[WIDTH-1]};
    acc_nxt = sum[WIDTH:1];
    low_nxt = {sum[0], low[WIDTH-1:1]};
    if (is_div) begin
      // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
      if (rem_sh >= {1'b0, opnd}) begin
        acc_nxt = rem_sh[WIDTH-1:0] - opnd;
        low_nxt = {low[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        low_nxt = {low[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative WIDTH-bit multiply/divide unit with valid/ready on both op and result sides.
// Signed MULT/DIV are enabled by defining MDU_SIGNED_EN; otherwise every op is unsigned.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_lo, neg_hi;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_nxt, low_nxt;

  logic             op_div, op_sgn, op_dz, s1, s2, fix_lo, fix_hi;
  logic [WIDTH-1:0] mag1, mag2;

  always_comb begin
    op_div = op_code inside {OP_DIV, OP_DIVU};
`ifdef MDU_SIGNED_EN
    op_sgn = op_code inside {OP_MULT, OP_DIV};
`else
    op_sgn = 1'b0;
`endif
    op_dz  = op_div && (in2 == '0);
    s1     = op_sgn && ($signed(in1) < 0);
    s2     = op_sgn && ($signed(in2) < 0);
    // Divide-by-zero keeps the raw dividend so the remainder comes out equal to in1.
    mag1   = (s1 && !op_dz) ? neg_w(in1) : in1;
    mag2   = s2 ? neg_w(in2) : in2;
    fix_lo = !op_dz && (s1 ^ s2);
    fix_hi = !op_dz && (op_div ? s1 : (s1 ^ s2));
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc     (hi),
    .low     (lo),
    .opnd    (opnd),
    .acc_nxt (acc_nxt),
    .low_nxt (low_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_ready  = (state == IDLE);
    res_valid = (state == DONE);
    case (state)
      IDLE: if (op_valid) state_nxt = BUSY;
      BUSY: if (cnt == '0) state_nxt = (neg_lo || neg_hi) ? FIX : DONE;
      FIX:  state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (op_valid) begin
          is_div      <= op_div;
          div_by_zero <= op_dz;
          neg_lo      <= fix_lo;
          neg_hi      <= fix_hi;
          hi          <= '0;
          lo          <= op_div ? mag1 : mag2;
          cnt         <= CW'(WIDTH - 1);
        end
        BUSY: begin
          hi  <= acc_nxt;
          lo  <= low_nxt;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (!is_div) begin
            {hi, lo} <= neg_dw({hi, lo});
          end else begin
            if (neg_lo) lo <= neg_w(lo);
            if (neg_hi) hi <= neg_w(hi);
          end
        end
        default: ;
      endcase
    end
  end

  // Multiplicand / divisor magnitude: data only, captured on accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && op_valid)
      opnd <= op_div ? mag2 : mag1;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expectations queued on accept, compared on result.
`timescale 1ns/1ps
module tb_mul_div_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, op_valid, op_ready, res_valid, res_ready, div_by_zero;
  logic [1:0]   op_code;
  logic [W-1:0] in1, in2, hi, lo;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t scoreboard[$];

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .in1         (in1),
    .in2         (in2),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic        sgn;
    longint      sa, sbv;
    logic [63:0] r;
`ifdef MDU_SIGNED_EN
    sgn = !code[0];
`else
    sgn = 1'b0;
`endif
    sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sbv = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    e.dbz = 1'b0;
    e.lat = W;
    if (!code[1]) begin
      r = sa * sbv;
      e.hi = r[63:32];
      e.lo = r[31:0];
      if (sgn && (a[W-1] ^ b[W-1])) e.lat = W + 1;
    end else if (b == '0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dbz = 1'b1;
    end else begin
      r = sa / sbv;
      e.lo = r[31:0];
      r = sa % sbv;
      e.hi = r[31:0];
      if (sgn && (a[W-1] || b[W-1])) e.lat = W + 1;
    end
    return e;
  endfunction

  task automatic issue_exp(input logic [1:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                           input int elat);
    exp_t e;
    int   n = 0;
    while (!op_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!op_ready) check("op_ready_wait", {63'b0, op_ready}, 64'd1);
    op_valid = 1'b1;
    op_code  = code;
    in1      = a;
    in2      = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_code  = 2'($urandom);
    in1      = $urandom;
    in2      = $urandom;
    e.hi = ehi; e.lo = elo; e.dbz = edz; e.lat = elat;
    scoreboard.push_back(e);
  endtask

  task automatic issue_model(input logic [1:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(code, a, b);
    issue_exp(code, a, b, e.hi, e.lo, e.dbz, e.lat);
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (scoreboard.size() == 0) begin
      check("sb_underflow", 64'd0, 64'd1);
      return;
    end
    e = scoreboard.pop_front();
    if (!res_valid) begin
      check("res_valid_timeout", {63'b0, res_valid}, 64'd1);
      return;
    end
    check("latency", 64'(n), 64'(e.lat));
    check("hi", {32'b0, hi}, {32'b0, e.hi});
    check("lo", {32'b0, lo}, {32'b0, e.lo});
    check("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dbz});
    for (int i = 0; i < hold; i++) begin
      op_valid = 1'b1;
      op_code  = 2'($urandom);
      in1      = $urandom;
      in2      = $urandom;
      @(posedge clk); #1;
      check("hold_hi", {32'b0, hi}, {32'b0, e.hi});
      check("hold_lo", {32'b0, lo}, {32'b0, e.lo});
      check("hold_op_ready", {63'b0, op_ready}, 64'd0);
      check("hold_res_valid", {63'b0, res_valid}, 64'd1);
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("drain_res_valid", {63'b0, res_valid}, 64'd0);
    check("drain_op_ready", {63'b0, op_ready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "tb_mul_div_unit timeout");
  end

  initial begin
    reset = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
    op_code = 2'b00; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_op_ready", {63'b0, op_ready}, 64'd1);
    check("rst_res_valid", {63'b0, res_valid}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_dbz", {63'b0, div_by_zero}, 64'd0);

    issue_exp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32);
    collect(0);
    issue_exp(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
    collect(0);
    issue_exp(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 32);
    collect(0);
    issue_exp(2'b11, 32'd40, 32'd6, 32'd4, 32'd6, 1'b0, 32);
    collect(0);

`ifdef MDU_SIGNED_EN
    issue_exp(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33);
    collect(0);
    issue_exp(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    collect(0);
    issue_exp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);
    collect(0);
`else
    issue_exp(2'b10, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0, 32);
    collect(0);
    issue_exp(2'b00, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1, 1'b0, 32);
    collect(0);
`endif

    issue_exp(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 32);
    collect(10);

    issue_model(2'b11, 32'd12345, 32'd17);
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(scoreboard.pop_back());
    check("abort_op_ready", {63'b0, op_ready}, 64'd1);
    check("abort_res_valid", {63'b0, res_valid}, 64'd0);
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_quiet", {63'b0, res_valid}, 64'd0);
    issue_exp(2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 32);
    collect(0);

    for (int i = 0; i < 12; i++) begin
      logic [1:0]   c;
      logic [W-1:0] a, b;
      c = 2'($urandom_range(0, 3));
      a = $urandom;
      if (i % 4 == 3)      b = '0;
      else if (i % 2 == 1) b = 32'($urandom_range(1, 20));
      else                 b = $urandom;
      issue_model(c, a, b);
      collect($urandom_range(0, 3));
    end

    check("sb_empty", 64'(scoreboard.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
